// File: rtl/muldiv_issue.sv
// muldiv_issue: RV32M issue/writeback sequencer between EX and MULDIV_top.
// Holds unit operands stable, stalls EX until the result returns.
module muldiv_issue #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [4:0]  req_rd,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        err_timeout,
  output logic        md_start,
  output logic [31:0] md_in_A,
  output logic [31:0] md_in_B,
  output logic [1:0]  md_op_mul,
  output logic [1:0]  md_op_div,
  output logic        md_muldiv_sel,
  input  logic [31:0] md_R,
  input  logic        md_done
);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    WB,
    DRAIN
  } state_t;

  localparam int CW = $clog2(TIMEOUT);

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] wd_cnt;
  logic          to_q;
  logic          req_ok;
  logic          capture;
  logic          wd_fire;
  logic          waiting;
  logic          ld_res;
  logic          ld_to;
  logic [31:0]   res_nx;

  assign req_ok  = req_valid & ~flush;
  assign capture = (state == IDLE) & req_ok;
  assign waiting = (state == WAIT) | (state == DRAIN);
  // count covers prior WAIT/DRAIN cycles; the firing cycle is the last one
  assign wd_fire = waiting & (wd_cnt >= CW'(TIMEOUT - 2));

  always_comb begin
    state_nx = state;
    ld_res   = 1'b0;
    ld_to    = 1'b0;
    res_nx   = md_R;
    unique case (state)
      IDLE: begin
        if (capture) state_nx = LAUNCH;
      end
      LAUNCH: begin
        state_nx = flush ? DRAIN : WAIT;
      end
      WAIT: begin
        if (flush) begin
          state_nx = md_done ? IDLE : DRAIN;
        end else if (md_done) begin
          state_nx = WB;
          ld_res   = 1'b1;
        end else if (wd_fire) begin
          state_nx = WB;
          ld_res   = 1'b1;
          ld_to    = 1'b1;
          res_nx   = 32'hFFFF_FFFF;
        end
      end
      WB: begin
        state_nx = IDLE;
      end
      DRAIN: begin
        if (md_done | wd_fire) state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      wd_cnt        <= '0;
      to_q          <= 1'b0;
      md_in_A       <= '0;
      md_in_B       <= '0;
      md_op_mul     <= '0;
      md_op_div     <= '0;
      md_muldiv_sel <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
    end else begin
      state <= state_nx;
      to_q  <= ld_to;
      if (capture) begin
        wd_cnt        <= '0;
        md_in_A       <= req_rs1;
        md_in_B       <= req_rs2;
        md_op_mul     <= req_funct3[1:0];
        md_op_div     <= req_funct3[1:0];
        md_muldiv_sel <= req_funct3[2];
        wb_rd         <= req_rd;
      end else if (waiting) begin
        wd_cnt <= wd_cnt + CW'(1);
      end
      if (ld_res) wb_data <= res_nx;
    end
  end

  assign stall = capture
               | (state == LAUNCH)
               | (state == WAIT)
               | ((state == DRAIN) & req_ok);

  assign busy     = (state != IDLE);
  assign md_start = (state == LAUNCH);
  assign wb_valid = (state == WB) & ~flush;

  assign err_timeout = ((state == WB) & to_q)
                     | ((state == DRAIN) & wd_fire & ~md_done);

endmodule

// File: tb/tb_muldiv_issue.sv
// tb_muldiv_issue: directed + random bench for muldiv_issue with a
// behavioural RV32M unit stand-in and arithmetic reference model.
module tb_muldiv_issue;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [2:0]  req_funct3;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic [4:0]  req_rd;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err_timeout;
  logic        md_start;
  logic [31:0] md_in_A;
  logic [31:0] md_in_B;
  logic [1:0]  md_op_mul;
  logic [1:0]  md_op_div;
  logic        md_muldiv_sel;
  logic [31:0] md_R;
  logic        md_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit md_pend = 1'b0;
  bit md_hang = 1'b0;
  int md_cnt  = 0;
  int md_lat  = 0;

  always #5 clk = ~clk;

  muldiv_issue #(.TIMEOUT(TO)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_funct3(req_funct3),
    .req_rs1(req_rs1),
    .req_rs2(req_rs2),
    .req_rd(req_rd),
    .flush(flush),
    .stall(stall),
    .busy(busy),
    .wb_valid(wb_valid),
    .wb_rd(wb_rd),
    .wb_data(wb_data),
    .err_timeout(err_timeout),
    .md_start(md_start),
    .md_in_A(md_in_A),
    .md_in_B(md_in_B),
    .md_op_mul(md_op_mul),
    .md_op_div(md_op_div),
    .md_muldiv_sel(md_muldiv_sel),
    .md_R(md_R),
    .md_done(md_done)
  );

  // RV32M semantics straight from the ISA definition
  function automatic logic [31:0] ref_op(input logic [2:0] f3,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'h0, b});
    p  = '0;
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb;
        return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb;
        return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, got, exp);
    end
  endtask

  // advance to mid-cycle; the stand-in unit answers from the held md_* ports
  task automatic next();
    logic [2:0] f3;
    @(negedge clk);
    cyc++;
    md_done = 1'b0;
    if (!reset) begin
      md_pend = 1'b0;
    end else begin
      if (md_pend) begin
        if (md_cnt == 0) begin
          f3 = {md_muldiv_sel,
                md_muldiv_sel ? md_op_div : md_op_mul};
          md_R    = ref_op(f3, md_in_A, md_in_B);
          md_done = 1'b1;
          md_pend = 1'b0;
        end else begin
          md_cnt--;
        end
      end
      if (md_start && !md_hang) begin
        md_pend = 1'b1;
        md_cnt  = md_lat;
      end
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    req_valid  = v;
    req_funct3 = f3;
    req_rs1    = a;
    req_rs2    = b;
    req_rd     = rd;
  endtask

  // one op from an idle cycle: done at k=2+lat, wb at k+1
  task automatic run_op(input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int lat);
    int k;
    k      = 2 + lat;
    md_lat = lat;
    for (int c = 0; c <= k + 1; c++) begin
      next();
      flush = 1'b0;
      drive(c <= k, f3, a, b, rd);
      #1;
      check("stall", 32'(stall), 32'(c <= k));
      check("start", 32'(md_start), 32'(c == 1));
      check("wb_valid", 32'(wb_valid), 32'(c == k + 1));
      check("busy", 32'(busy), 32'(c >= 1));
      if (c >= 1 && c <= k) begin
        check("in_A", md_in_A, a);
        check("in_B", md_in_B, b);
        check("sel", 32'({md_muldiv_sel, md_op_mul, md_op_div}),
              32'({f3[2], f3[1:0], f3[1:0]}));
      end
      if (c == k + 1) begin
        check("wb_data", wb_data, ref_op(f3, a, b));
        check("wb_rd", 32'(wb_rd), 32'(rd));
        check("err_to", 32'(err_timeout), 32'(0));
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"},
          32'({stall, busy, wb_valid, err_timeout, md_start,
               md_muldiv_sel, md_op_mul, md_op_div, wb_rd}), 32'(0));
    check({tag, "_A"}, md_in_A, 32'h0);
    check({tag, "_B"}, md_in_B, 32'h0);
    check({tag, "_data"}, wb_data, 32'h0);
  endtask

  initial begin
    int wbs;
    reset   = 1'b0;
    flush   = 1'b0;
    md_done = 1'b0;
    md_R    = '0;
    drive(1'b0, 3'd0, 32'h0, 32'h0, 5'd0);
    #2;
    check_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    // MUL 7 * -3
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 3);

    // back-to-back DIV then REMU
    run_op(3'd4, 32'd100, 32'd7, 5'd1, 4);
    run_op(3'd7, 32'd100, 32'd7, 5'd2, 2);

    // rd = x0 still completes
    run_op(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0, 0);

    // flush DIVU in 5th WAIT cycle, MUL queued during DRAIN
    md_lat = 10;
    wbs = 0;
    for (int c = 0; c <= 17; c++) begin
      next();
      flush = (c == 6);
      if (c <= 6)      drive(1'b1, 3'd5, 32'd1000, 32'd3, 5'd4);
      else if (c == 7) drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
      else             drive(c < 17, 3'd0, 32'd3, 32'd4, 5'd9);
      if (c == 8) md_lat = 1;
      #1;
      if (wb_valid) wbs++;
      check("fl_stall", 32'(stall), 32'(c != 7 && c != 17));
      check("fl_start", 32'(md_start), 32'(c == 1 || c == 14));
      check("fl_wbv", 32'(wb_valid), 32'(c == 17));
      if (c == 17) begin
        check("fl_data", wb_data, 32'd12);
        check("fl_rd", 32'(wb_rd), 32'd9);
      end
    end
    check("fl_wbcount", 32'(wbs), 32'd1);

    // md_done and flush together in WAIT
    md_lat = 3;
    for (int c = 0; c <= 7; c++) begin
      next();
      flush = (c == 5);
      drive(c <= 5, 3'd6, 32'd50, 32'd8, 5'd3);
      #1;
      check("df_wbv", 32'(wb_valid), 32'(0));
      check("df_busy", 32'(busy), 32'(c >= 1 && c <= 5));
      if (c == 5) check("df_done", 32'(md_done), 32'(1));
    end

    // watchdog: unit never answers
    md_hang = 1'b1;
    for (int c = 0; c <= TO + 2; c++) begin
      next();
      flush = 1'b0;
      drive(c <= TO, 3'd1, 32'd9, 32'd9, 5'd11);
      #1;
      check("to_err", 32'(err_timeout), 32'(c == TO + 1));
      check("to_wbv", 32'(wb_valid), 32'(c == TO + 1));
      check("to_stall", 32'(stall), 32'(c <= TO));
      if (c == TO + 1) begin
        check("to_data", wb_data, 32'hFFFF_FFFF);
        check("to_rd", 32'(wb_rd), 32'd11);
      end
    end
    md_hang = 1'b0;

    // async reset mid-WAIT
    md_lat = 20;
    for (int c = 0; c <= 5; c++) begin
      next();
      drive(1'b1, 3'd4, 32'd77, 32'd5, 5'd6);
    end
    #1;
    check("pre_rst_busy", 32'(busy), 32'(1));
    drive(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    reset   = 1'b0;
    md_done = 1'b0;
    md_pend = 1'b0;
    #1;
    check_zero("midrst");
    next();
    reset = 1'b1;
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 1);
    check("mulhu", wb_data, 32'hFFFF_FFFE);

    // random ops against the reference model
    for (int i = 0; i < 24; i++) begin
      run_op(3'($urandom_range(0, 7)), pick(), pick(),
             5'($urandom_range(0, 31)), $urandom_range(0, 8));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
